// File: rtl/mem_port_arbiter.sv
// Shared memory command port arbiter: fetch vs load/store,
// fixed-latency read tagging and start-up memory clear.
module mem_port_arbiter #(
  parameter int N           = 8,
  parameter int M           = 32,
  parameter int LAT         = 5,
  parameter int MAXWAIT     = 3,
  parameter int INIT_CYCLES = 2
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         if_req,
  input  logic [N-1:0] if_addr,
  output logic         if_gnt,
  output logic         if_rvalid,
  output logic [M-1:0] if_rdata,
  input  logic         d_req,
  input  logic         d_rw,
  input  logic [N-1:0] d_addr,
  input  logic [M-1:0] d_wdata,
  output logic         d_gnt,
  output logic         d_rvalid,
  output logic [M-1:0] d_rdata,
  output logic [N-1:0] mem_mar,
  output logic [M-1:0] mem_data,
  output logic         mem_ce,
  output logic         mem_rw,
  output logic         mem_clr,
  input  logic [M-1:0] mem_rdata
);

  localparam int WW = (MAXWAIT < 1) ? 1 : $clog2(MAXWAIT + 1);
  localparam int IW = (INIT_CYCLES < 2) ? 1 : $clog2(INIT_CYCLES + 1);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  state_t state_q, state_d;
  logic [IW-1:0] init_cnt_q, init_cnt_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;

  logic         run;
  logic         fetch_win;

  logic [N-1:0] mar_q, mar_d;
  logic [M-1:0] data_q, data_d;
  logic         ce_q, ce_d;
  logic         rw_q, rw_d;
  logic         own_q, own_d;
  logic         mclr_q, mclr_d;

  logic [LAT-1:0] tag_v_q, tag_v_d;
  logic [LAT-1:0] tag_o_q, tag_o_d;

  // state register and start-up clear counter
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= S_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // next state: hold INIT for INIT_CYCLES cycles, then RUN forever
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    unique case (state_q)
      S_INIT: begin
        if (init_cnt_q == IW'(INIT_CYCLES - 1))
          state_d = S_RUN;
        else
          init_cnt_d = init_cnt_q + 1'b1;
      end
      S_RUN: begin
        state_d = S_RUN;
      end
      default: state_d = S_INIT;
    endcase
  end

  // grant outputs: data side wins unless fetch has starved
  always_comb begin
    run       = (state_q == S_RUN) && !clr;
    fetch_win = if_req &&
                (!d_req || (wait_cnt_q == WW'(MAXWAIT)));
    if_gnt    = run && fetch_win;
    d_gnt     = run && d_req && !fetch_win;
  end

  // starvation counter: consecutive denied fetch cycles, saturating
  always_comb begin
    wait_cnt_d = '0;
    if (run && if_req && !if_gnt) begin
      if (wait_cnt_q == WW'(MAXWAIT))
        wait_cnt_d = wait_cnt_q;
      else
        wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // command register contents from the winner; hold when idle
  always_comb begin
    mar_d  = mar_q;
    data_d = data_q;
    rw_d   = rw_q;
    own_d  = own_q;
    ce_d   = 1'b0;
    mclr_d = (state_d == S_INIT);
    if (if_gnt) begin
      mar_d  = if_addr;
      data_d = '0;
      rw_d   = 1'b0;
      own_d  = 1'b0;
      ce_d   = 1'b1;
    end else if (d_gnt) begin
      mar_d  = d_addr;
      data_d = d_wdata;
      rw_d   = d_rw;
      own_d  = 1'b1;
      ce_d   = 1'b1;
    end
  end

  // tag pipe fed by the issued command, one stage per latency cycle
  always_comb begin
    tag_v_d    = '0;
    tag_o_d    = '0;
    tag_v_d[0] = ce_q && !rw_q;
    tag_o_d[0] = own_q;
    for (int i = 1; i < LAT; i++) begin
      tag_v_d[i] = tag_v_q[i-1];
      tag_o_d[i] = tag_o_q[i-1];
    end
  end

  // command and tag registers
  always_ff @(posedge clk) begin
    if (clr) begin
      mar_q   <= '0;
      data_q  <= '0;
      ce_q    <= 1'b0;
      rw_q    <= 1'b0;
      own_q   <= 1'b0;
      mclr_q  <= 1'b1;
      tag_v_q <= '0;
      tag_o_q <= '0;
      wait_cnt_q <= '0;
    end else begin
      mar_q   <= mar_d;
      data_q  <= data_d;
      ce_q    <= ce_d;
      rw_q    <= rw_d;
      own_q   <= own_d;
      mclr_q  <= mclr_d;
      tag_v_q <= tag_v_d;
      tag_o_q <= tag_o_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // read return routing by the emerging tag
  always_comb begin
    if_rvalid = tag_v_q[LAT-1] && !tag_o_q[LAT-1] && !clr;
    d_rvalid  = tag_v_q[LAT-1] && tag_o_q[LAT-1] && !clr;
    if_rdata  = mem_rdata;
    d_rdata   = mem_rdata;
  end

  assign mem_mar  = mar_q;
  assign mem_data = data_q;
  assign mem_ce   = ce_q;
  assign mem_rw   = rw_q;
  assign mem_clr  = mclr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a response scoreboard
// and a cycle model of the grant and command registers.
module tb_mem_port_arbiter;

  localparam int N    = 8;
  localparam int M    = 32;
  localparam int LAT  = 5;
  localparam int MAXW = 3;
  localparam int INIT = 2;

  logic         clk = 1'b0;
  logic         clr;
  logic         if_req;
  logic [N-1:0] if_addr;
  logic         if_gnt;
  logic         if_rvalid;
  logic [M-1:0] if_rdata;
  logic         d_req;
  logic         d_rw;
  logic [N-1:0] d_addr;
  logic [M-1:0] d_wdata;
  logic         d_gnt;
  logic         d_rvalid;
  logic [M-1:0] d_rdata;
  logic [N-1:0] mem_mar;
  logic [M-1:0] mem_data;
  logic         mem_ce;
  logic         mem_rw;
  logic         mem_clr;
  logic [M-1:0] mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .N(N), .M(M), .LAT(LAT),
    .MAXWAIT(MAXW), .INIT_CYCLES(INIT)
  ) dut (
    .clk(clk), .clr(clr),
    .if_req(if_req), .if_addr(if_addr),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata),
    .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_mar(mem_mar), .mem_data(mem_data),
    .mem_ce(mem_ce), .mem_rw(mem_rw),
    .mem_clr(mem_clr), .mem_rdata(mem_rdata)
  );

  typedef struct {
    int           due;
    bit           own;
    logic [N-1:0] addr;
  } rsp_t;

  rsp_t sb[$];

  int ntests = 0;
  int nfail  = 0;
  int cyc    = 0;
  int since_rst = 0;
  int wcnt   = 0;
  int rv_seen = 0;
  int last_g = 0;
  int mark;

  logic         e_ce, e_rw, e_mclr;
  logic [N-1:0] e_mar;
  logic [M-1:0] e_data;
  logic [15:0]  pat;

  function automatic logic [M-1:0] f(input logic [N-1:0] a);
    return {a, ~a, 16'h5A5A};
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    bit run, fw, eig, edg, due, ev;
    rsp_t r;
    due = (sb.size() > 0) && (sb[0].due == cyc);
    if (due) mem_rdata = f(sb[0].addr);
    else     mem_rdata = 32'hBAD00000 | cyc;
    #1;
    run = !clr && (since_rst >= INIT);
    fw  = if_req && (!d_req || wcnt == MAXW);
    eig = run && fw;
    edg = run && d_req && !fw;
    chk("if_gnt", 64'(if_gnt), 64'(eig));
    chk("d_gnt", 64'(d_gnt), 64'(edg));
    chk("mem_ce", 64'(mem_ce), 64'(e_ce));
    chk("mem_rw", 64'(mem_rw), 64'(e_rw));
    chk("mem_mar", 64'(mem_mar), 64'(e_mar));
    chk("mem_data", 64'(mem_data), 64'(e_data));
    chk("mem_clr", 64'(mem_clr), 64'(e_mclr));
    ev = due && !clr;
    chk("if_rvalid", 64'(if_rvalid),
        64'(ev && !sb[0].own));
    chk("d_rvalid", 64'(d_rvalid),
        64'(ev && sb[0].own));
    if (ev && !sb[0].own)
      chk("if_rdata", 64'(if_rdata), 64'(f(sb[0].addr)));
    if (ev && sb[0].own)
      chk("d_rdata", 64'(d_rdata), 64'(f(sb[0].addr)));
    if (due) void'(sb.pop_front());
    rv_seen += int'(if_rvalid) + int'(d_rvalid);
    last_g = eig ? 1 : (edg ? 2 : 0);
    if (clr) begin
      e_ce = 0; e_rw = 0; e_mar = '0; e_data = '0;
      e_mclr = 1; since_rst = 0; wcnt = 0;
      sb.delete();
    end else begin
      if (since_rst < 1000) since_rst++;
      e_mclr = (since_rst < INIT);
      e_ce = eig || edg;
      if (eig) begin
        e_mar = if_addr; e_data = '0; e_rw = 0;
        r.due = cyc + 1 + LAT; r.own = 0;
        r.addr = if_addr; sb.push_back(r);
      end else if (edg) begin
        e_mar = d_addr; e_data = d_wdata; e_rw = d_rw;
        if (!d_rw) begin
          r.due = cyc + 1 + LAT; r.own = 1;
          r.addr = d_addr; sb.push_back(r);
        end
      end
      if (!run) wcnt = 0;
      else if (if_req && !eig)
        wcnt = (wcnt < MAXW) ? wcnt + 1 : MAXW;
      else wcnt = 0;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    if_req = 0; d_req = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr = 1; if_req = 0; if_addr = '0;
    d_req = 0; d_rw = 0; d_addr = '0; d_wdata = '0;
    mem_rdata = '0;
    e_ce = 0; e_rw = 0; e_mar = '0; e_data = '0;
    e_mclr = 1; pat = '0;
    @(posedge clk); @(posedge clk); #1;
    step();

    clr = 0; if_req = 1; d_req = 1;
    if_addr = 8'h01; d_addr = 8'h02;
    step(); step();
    chk("init_nogrant", 64'(last_g), 64'd0);
    step();
    chk("first_gnt_d", 64'(last_g), 64'd2);
    idle(8);

    mark = rv_seen;
    if_req = 1; if_addr = 8'h10;
    step();
    chk("fetch_gnt", 64'(last_g), 64'd1);
    idle(8);
    chk("fetch_rsp_cnt", 64'(rv_seen - mark), 64'd1);

    for (int i = 0; i < 8; i++) begin
      if_req = 1; d_req = 1; d_rw = 0;
      if_addr = 8'h80 + 8'(i);
      d_addr  = 8'h40 + 8'(i);
      step();
      pat = {pat[13:0], 2'(last_g)};
    end
    chk("starve_pattern", 64'(pat), 64'hA9A9);
    idle(8);

    mark = rv_seen;
    d_req = 1; d_rw = 1; d_addr = 8'h22;
    d_wdata = 32'h12345678;
    step();
    d_req = 0; d_rw = 0;
    if_req = 1; if_addr = 8'h30;
    step();
    chk("wr_rw", 64'(mem_rw), 64'd0);
    idle(8);
    chk("wr_rd_rsp_cnt", 64'(rv_seen - mark), 64'd1);

    mark = rv_seen;
    if_req = 1; d_req = 0; if_addr = 8'h51; step();
    if_req = 0; d_req = 1; d_addr  = 8'h52; step();
    if_req = 1; d_req = 0; if_addr = 8'h53; step();
    if_req = 0; d_req = 1; d_addr  = 8'h54; step();
    idle(8);
    chk("burst_rsp_cnt", 64'(rv_seen - mark), 64'd4);

    d_req = 0;
    if_req = 1; if_addr = 8'h61; step();
    if_addr = 8'h62; step();
    if_addr = 8'h63; step();
    if_req = 0;
    mark = rv_seen;
    clr = 1; step();
    clr = 0;
    idle(12);
    chk("flush_rsp_cnt", 64'(rv_seen - mark), 64'd0);
    if_req = 1; if_addr = 8'h70; step();
    idle(8);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single shared memory command port of the 3-stage pipeline between the instruction-fetch requester and the load/store requester. It drives the address/data/chip-enable/read-write/clear command lines into the fixed-latency memory delay path. It tracks every issued read through a tag pipeline matching that latency, and routes returning read data back to the requester that issued it. The block also sequences the memory clear at start-up and grants no requests until the clear completes.

## Interface
- N, 8, address width
- M, 32, data width
- LAT, 5, cycles from a command on mem_* to valid mem_rdata (delay path + memory)
- MAXWAIT, 3, consecutive denied fetch cycles before fetch is forced to win
- INIT_CYCLES, 2, cycles mem_clr is held after reset

- clk  in  1  clock; all state updates on posedge
- clr  in  1  reset, synchronous, active-high
- if_req  in  1  fetch read request
- if_addr  in  N  fetch address
- if_gnt  out  1  fetch request accepted this cycle (combinational)
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  M  fetch read data
- d_req  in  1  data-side request
- d_rw  in  1  1 = write, 0 = read
- d_addr  in  N  data address
- d_wdata  in  M  write data
- d_gnt  out  1  data request accepted this cycle (combinational)
- d_rvalid  out  1  data read data valid (reads only)
- d_rdata  out  M  data read data
- mem_mar  out  N  registered command address
- mem_data  out  M  registered write data
- mem_ce  out  1  registered command valid
- mem_rw  out  1  registered 1 = write
- mem_clr  out  1  registered memory clear
- mem_rdata  in  M  read data returned from memory

## Operation
- States: INIT, RUN.
- INIT: entered on clr. mem_clr=1 and mem_ce=0 for exactly INIT_CYCLES cycles after clr deasserts, then the block moves to RUN. No grants are given in INIT.
- RUN: at most one grant per cycle, and a grant is possible every cycle.
- Priority: d_req wins over if_req, except when wait_cnt==MAXWAIT, in which case fetch wins.
- wait_cnt counts cycles with if_req=1 and if_gnt=0. It saturates at MAXWAIT and clears on if_gnt or when if_req=0.
- On a grant, the next posedge loads mem_mar, mem_data, mem_rw and mem_ce=1 from the winner. Fetch always issues with rw=0 and data=0.
- Cycles without a grant produce mem_ce=0. mem_mar, mem_data and mem_rw then hold their last values.
- Tag pipe: LAT-stage shift register of {valid, owner}. It is loaded alongside mem_ce, and valid is set only for reads. Stage LAT-1 emerging at cycle t+LAT drives the selected requester's rvalid=1 with rdata=mem_rdata, combinationally.
- Writes are fire-and-forget: they produce no rvalid.
- rdata outputs pass mem_rdata through at all times and are meaningful only while the matching rvalid is high.

## Timing
- Reset values: if_gnt=d_gnt=0, both rvalid=0, mem_ce=0, mem_rw=0, mem_mar=0, mem_data=0, mem_clr=1 (while clr and throughout INIT), tag pipe all invalid, wait_cnt=0.
- gnt is asserted in cycle t. mem_ce=1 is asserted in cycle t+1. The read response rvalid is asserted in cycle t+1+LAT.
- Throughput is one command per cycle. Responses come back in issue order, with no reordering.
- Simultaneous requests resolve by the priority rule; the loser's gnt=0 and it must hold its request.
- Reset mid-operation: the tag pipe is cleared, so in-flight reads produce no rvalid. The block re-enters INIT.
- wait_cnt at MAXWAIT with d_req=0 gives fetch a normal grant; the counter clears.

## Test plan
- Reset, INIT_CYCLES=2: mem_clr=1 for 2 cycles after clr drops. No gnt during those cycles, even with both reqs held high. First gnt comes on the 3rd cycle.
- Single fetch read of addr 0x10 granted at cycle t: mem_ce=1, mem_mar=0x10, mem_rw=0 at t+1. Drive mem_rdata=0xDEADBEEF at t+6: if_rvalid=1, if_rdata=0xDEADBEEF, d_rvalid=0.
- d_req and if_req both held high continuously, MAXWAIT=3: grant pattern is d,d,d,if,d,d,d,if.
- Write d_addr=0x22, d_wdata=0x12345678 followed back-to-back by a fetch read: mem_rw=1 then 0 on consecutive cycles. No rvalid for the write; if_rvalid appears exactly LAT cycles after the read command.
- Four back-to-back reads alternating owners: four rvalids on consecutive cycles, each to the correct owner, in order.
- clr asserted with 3 reads in flight: no rvalid is observed afterwards, and INIT replays.
